// File: rtl/rf_riscv_sb_if.sv
// Register-file / scoreboard port bundle: read ports, writeback, issue reservation.
// The master drives addresses, writeback and issue requests; the slave is the register file.
interface rf_riscv_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   read_addr1_i;
  logic [AW-1:0]   read_addr2_i;
  logic [XLEN-1:0] read_data1_o;
  logic [XLEN-1:0] read_data2_o;
  logic            busy1_o;
  logic            busy2_o;
  logic            write_enable_i;
  logic [AW-1:0]   write_addr_i;
  logic [XLEN-1:0] write_data_i;
  logic            issue_valid_i;
  logic [AW-1:0]   issue_rd_i;
  logic            issue_ready_o;
  logic [AW:0]     busy_count_o;

  modport master (
    output read_addr1_i, read_addr2_i, write_enable_i, write_addr_i, write_data_i,
           issue_valid_i, issue_rd_i,
    input  read_data1_o, read_data2_o, busy1_o, busy2_o, issue_ready_o, busy_count_o
  );

  modport slave (
    input  read_addr1_i, read_addr2_i, write_enable_i, write_addr_i, write_data_i,
           issue_valid_i, issue_rd_i,
    output read_data1_o, read_data2_o, busy1_o, busy2_o, issue_ready_o, busy_count_o
  );
endinterface

// File: rtl/rf_riscv_sb.sv
// RISC-V integer register file with a busy-bit scoreboard for in-flight writebacks.
// Two combinational read ports, one writeback port, one destination-reservation port.
module rf_riscv_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  rf_riscv_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     count_q, count_d;

  logic wr_en;
  logic fwd1, fwd2;
  logic issue_ready;
  logic issue_set;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  assign wr_en = bus.write_enable_i && (bus.write_addr_i != '0);

  // Same-cycle writeback is visible to readers only when forwarding is enabled.
  assign fwd1 = (BYPASS != 0) && wr_en && (bus.write_addr_i == bus.read_addr1_i);
  assign fwd2 = (BYPASS != 0) && wr_en && (bus.write_addr_i == bus.read_addr2_i);

  assign bus.read_data1_o = (bus.read_addr1_i == '0) ? '0 :
                            fwd1 ? bus.write_data_i : regs_q[bus.read_addr1_i];
  assign bus.read_data2_o = (bus.read_addr2_i == '0) ? '0 :
                            fwd2 ? bus.write_data_i : regs_q[bus.read_addr2_i];

  assign bus.busy1_o = busy_q[bus.read_addr1_i] && !fwd1;
  assign bus.busy2_o = busy_q[bus.read_addr2_i] && !fwd2;

  // A writeback landing on the requested register this cycle frees it for re-reservation.
  assign issue_ready = !busy_q[bus.issue_rd_i] || (bus.issue_rd_i == '0) ||
                       (bus.write_enable_i && (bus.write_addr_i == bus.issue_rd_i));
  assign bus.issue_ready_o = issue_ready;
  assign issue_set = bus.issue_valid_i && issue_ready && (bus.issue_rd_i != '0);

  always_comb begin
    busy_d = busy_q;
    if (wr_en)     busy_d[bus.write_addr_i] = 1'b0;
    if (issue_set) busy_d[bus.issue_rd_i]   = 1'b1;
    count_d = popcount(busy_d);
  end

  assign bus.busy_count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.write_addr_i] <= bus.write_data_i;
    end
  end
endmodule

// File: tb/tb_rf_riscv_sb.sv
// Directed bench for rf_riscv_sb: one forwarding and one non-forwarding instance
// driven with identical stimulus.
module tb_rf_riscv_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   ra1 = '0, ra2 = '0, wa = '0, ird = '0;
  logic [XLEN-1:0] wd = '0;
  logic            we = 1'b0, iv = 1'b0;

  rf_riscv_sb_if #(.XLEN(XLEN), .NREG(NREG)) ifa ();
  rf_riscv_sb_if #(.XLEN(XLEN), .NREG(NREG)) ifb ();

  assign ifa.read_addr1_i = ra1;  assign ifb.read_addr1_i = ra1;
  assign ifa.read_addr2_i = ra2;  assign ifb.read_addr2_i = ra2;
  assign ifa.write_enable_i = we; assign ifb.write_enable_i = we;
  assign ifa.write_addr_i = wa;   assign ifb.write_addr_i = wa;
  assign ifa.write_data_i = wd;   assign ifb.write_data_i = wd;
  assign ifa.issue_valid_i = iv;  assign ifb.issue_valid_i = iv;
  assign ifa.issue_rd_i = ird;    assign ifb.issue_rd_i = ird;

  rf_riscv_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifa));
  rf_riscv_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifb));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    ird = 5'd5;
    #2;
    chk("rst_rd1", ifa.read_data1_o, 32'h0);
    chk("rst_rd2", ifa.read_data2_o, 32'h0);
    chk("rst_busy1", {31'h0, ifa.busy1_o}, 32'h0);
    chk("rst_count", {26'h0, ifa.busy_count_o}, 32'h0);
    chk("rst_ready", {31'h0, ifa.issue_ready_o}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic write/read and x0 immunity
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    step();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    chk("x5_rd1", ifa.read_data1_o, 32'hDEADBEEF);
    chk("x5_rd2", ifa.read_data2_o, 32'hDEADBEEF);
    chk("x5_rd1_nobyp", ifb.read_data1_o, 32'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'h1234; ra1 = 5'd0;
    step();
    we = 1'b0;
    #1;
    chk("x0_rd1", ifa.read_data1_o, 32'h0);
    chk("x0_busy", {31'h0, ifa.busy1_o}, 32'h0);

    // Same-cycle forwarding
    ra1 = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
    #1;
    chk("byp_rd1", ifa.read_data1_o, 32'hA5A5A5A5);
    chk("nobyp_rd1", ifb.read_data1_o, 32'h0);
    step();
    we = 1'b0;
    #1;
    chk("nobyp_after", ifb.read_data1_o, 32'hA5A5A5A5);

    // Reserve x3, reject duplicate, release by writeback
    iv = 1'b1; ird = 5'd3; ra1 = 5'd3;
    #1;
    chk("iss3_ready", {31'h0, ifa.issue_ready_o}, 32'h1);
    step();
    chk("iss3_busy1", {31'h0, ifa.busy1_o}, 32'h1);
    chk("iss3_count", {26'h0, ifa.busy_count_o}, 32'd1);
    chk("iss3_dup_ready", {31'h0, ifa.issue_ready_o}, 32'h0);
    step();
    chk("iss3_dup_count", {26'h0, ifa.busy_count_o}, 32'd1);
    chk("iss3_dup_busy", {31'h0, ifa.busy1_o}, 32'h1);
    iv = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'h33;
    #1;
    chk("wb3_busy_byp", {31'h0, ifa.busy1_o}, 32'h0);
    chk("wb3_busy_nobyp", {31'h0, ifb.busy1_o}, 32'h1);
    step();
    we = 1'b0;
    #1;
    chk("wb3_busy", {31'h0, ifa.busy1_o}, 32'h0);
    chk("wb3_count", {26'h0, ifa.busy_count_o}, 32'd0);
    chk("wb3_data", ifa.read_data1_o, 32'h33);

    // Write and re-reserve x9 in one cycle: set wins
    iv = 1'b1; ird = 5'd9;
    step();
    chk("iss9_count", {26'h0, ifa.busy_count_o}, 32'd1);
    we = 1'b1; wa = 5'd9; wd = 32'h99;
    #1;
    chk("iss9_wb_ready", {31'h0, ifa.issue_ready_o}, 32'h1);
    step();
    we = 1'b0; iv = 1'b0; ra1 = 5'd9;
    #1;
    chk("x9_data", ifa.read_data1_o, 32'h99);
    chk("x9_busy", {31'h0, ifa.busy1_o}, 32'h1);
    chk("x9_count", {26'h0, ifa.busy_count_o}, 32'd1);

    // Set x4 while clearing x6: count unchanged
    iv = 1'b1; ird = 5'd6;
    step();
    chk("iss6_count", {26'h0, ifa.busy_count_o}, 32'd2);
    ird = 5'd4; we = 1'b1; wa = 5'd6; wd = 32'h66;
    step();
    iv = 1'b0; we = 1'b0; ra1 = 5'd4; ra2 = 5'd6;
    #1;
    chk("x4_busy", {31'h0, ifa.busy1_o}, 32'h1);
    chk("x6_busy", {31'h0, ifa.busy2_o}, 32'h0);
    chk("x4x6_count", {26'h0, ifa.busy_count_o}, 32'd2);
    iv = 1'b1; ird = 5'd0;
    #1;
    chk("iss0_ready", {31'h0, ifa.issue_ready_o}, 32'h1);
    step();
    iv = 1'b0;
    #1;
    chk("iss0_count", {26'h0, ifa.busy_count_o}, 32'd2);

    // Fill every register busy; already-busy ones are simply not accepted
    for (int i = 1; i < NREG; i++) begin
      iv = 1'b1; ird = AW'(i);
      step();
    end
    iv = 1'b0;
    #1;
    chk("full_count", {26'h0, ifa.busy_count_o}, 32'd31);
    ird = 5'd31;
    #1;
    chk("full_ready31", {31'h0, ifa.issue_ready_o}, 32'h0);

    // Asynchronous reset between edges
    ra1 = 5'd5; ra2 = 5'd7;
    iv = 1'b1; ird = 5'd3; we = 1'b1; wa = 5'd12; wd = 32'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", {26'h0, ifa.busy_count_o}, 32'd0);
    chk("arst_rd1", ifa.read_data1_o, 32'h0);
    chk("arst_rd2_nobyp", ifb.read_data2_o, 32'h0);
    chk("arst_busy1", {31'h0, ifa.busy1_o}, 32'h0);
    chk("arst_ready", {31'h0, ifa.issue_ready_o}, 32'h1);

    // First edge after release behaves normally
    iv = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; wa = 5'd12; wd = 32'h0000000C;
    iv = 1'b1; ird = 5'd3;
    step();
    we = 1'b0; iv = 1'b0; ra1 = 5'd12; ra2 = 5'd3;
    #1;
    chk("post_rst_data", ifb.read_data1_o, 32'hC);
    chk("post_rst_busy3", {31'h0, ifa.busy2_o}, 32'h1);
    chk("post_rst_count", {26'h0, ifa.busy_count_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
